// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: constants and types shared by the ID/EX pipeline stage.
//   INST_NOP     - canonical RV bubble instruction (addi x0, x0, 0)
//   XLEN_DEF     - default operand / PC width
//   REG_AW_DEF   - default register-file address width
//   pipe_state_e - control FSM state encoding
//   payload_w()  - width of the packed slot record
//                  {inst, inst_addr, op1, op2, rd_addr, reg_wen}
package id_ex_pipe_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam int          XLEN_DEF   = 64;
    localparam int          REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    function automatic int payload_w(input int xlen, input int reg_aw);
        return 32 + 3 * xlen + reg_aw + 1;
    endfunction

endpackage

// File: rtl/id_ex_pipe_slot.sv
// id_ex_pipe_slot: one payload register of the ID/EX stage with a valid bit.
// The instruction word occupies the top 32 bits of the record, so the bubble
// value is INST_NOP followed by zeros.
//   clk   in  clock
//   rst   in  synchronous active-low reset (slot becomes an invalid bubble)
//   load  in  capture d and mark valid
//   clear in  replace contents with the bubble and mark invalid (wins over load)
//   d     in  W-bit packed payload
//   q     out W-bit stored payload
//   valid out slot holds a live instruction
module id_ex_pipe_slot
    import id_ex_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    localparam logic [W-1:0] BUBBLE = {INST_NOP, {(W-32){1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            q     <= BUBBLE;
            valid <= 1'b0;
        end else if (clear) begin
            q     <= BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with valid/ready flow control,
// synchronous flush and an optional skid buffer.
//
// Build option: define ID_EX_SKID_EN to add the skid slot S and a registered
// ready_o (two-deep buffering). Without it ready_o = !valid_o || ready_i.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   flush_i               drop everything held (redirect)
//   valid_i / ready_o     handshake with decode
//   inst_i .. reg_wen_i   payload from decode
//   valid_o / ready_i     handshake with execute (ready_i low = stall)
//   inst_o .. reg_wen_o   registered payload to execute (NOP bubble when idle)
//
// state    | meaning
// ST_EMPTY | M holds the bubble, nothing offered to execute
// ST_FULL  | M valid, S empty
// ST_SKID  | M and S valid, upstream stalled (skid build only)
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_wen_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_wen_o
);

    localparam int PW = payload_w(XLEN, REG_AW);

    pipe_state_e state, state_nxt;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] m_d, m_q;
    logic          m_load, m_clear, m_valid;
    logic          accept, issue;

    assign in_pl = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};

    id_ex_pipe_slot #(.W(PW)) u_slot_m (
        .clk   (clk),
        .rst   (rst),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .q     (m_q),
        .valid (m_valid)
    );

    assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = m_q;
    assign valid_o = m_valid;

`ifdef ID_EX_SKID_EN
    logic [PW-1:0] s_q;
    logic          s_load, s_clear, s_valid;

    id_ex_pipe_slot #(.W(PW)) u_slot_s (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_pl),
        .q     (s_q),
        .valid (s_valid)
    );

    // Registered: depends only on the S valid flop, never on ready_i.
    assign ready_o = !s_valid;
    // M refills from S only when draining the skid entry.
    assign m_d     = (state == ST_SKID) ? s_q : in_pl;
`else
    assign ready_o = !valid_o || ready_i;
    assign m_d     = in_pl;
`endif

    assign accept = valid_i && ready_o;
    assign issue  = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_load    = 1'b0;
        m_clear   = 1'b0;
`ifdef ID_EX_SKID_EN
        s_load    = 1'b0;
        s_clear   = 1'b0;
`endif
        if (flush_i) begin
            // A same-cycle issue is still consumed by execute; accept is dropped.
            state_nxt = ST_EMPTY;
            m_clear   = 1'b1;
`ifdef ID_EX_SKID_EN
            s_clear   = 1'b1;
`endif
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_load    = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && issue) begin
                        m_load = 1'b1;
                    end
`ifdef ID_EX_SKID_EN
                    else if (accept) begin
                        s_load    = 1'b1;
                        state_nxt = ST_SKID;
                    end
`endif
                    else if (issue) begin
                        m_clear   = 1'b1;
                        state_nxt = ST_EMPTY;
                    end
                end
`ifdef ID_EX_SKID_EN
                ST_SKID: begin
                    if (issue) begin
                        m_load    = 1'b1;
                        s_clear   = 1'b1;
                        state_nxt = ST_FULL;
                    end
                end
`endif
                default: begin
                    m_clear   = 1'b1;
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       inst_i;
    logic [XLEN-1:0]   inst_addr_i;
    logic [XLEN-1:0]   op1_i;
    logic [XLEN-1:0]   op2_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              reg_wen_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       inst_o;
    logic [XLEN-1:0]   inst_addr_o;
    logic [XLEN-1:0]   op1_o;
    logic [XLEN-1:0]   op2_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              reg_wen_o;

    int checks = 0;
    int errors = 0;

    id_ex_pipe #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .reg_wen_i   (reg_wen_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .rd_addr_o   (rd_addr_o),
        .reg_wen_o   (reg_wen_o)
    );

    always #5 clk = ~clk;

    // Directed payload k: inst 0x1000_0000+k, PC 0x8000_0000+4k, etc.
    function automatic logic [31:0] e_inst(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction
    function automatic logic [63:0] e_addr(input int k);
        return 64'h8000_0000 + 64'(4 * k);
    endfunction
    function automatic logic [63:0] e_op1(input int k);
        return 64'h1111_0000_0000_0000 | 64'(k);
    endfunction
    function automatic logic [63:0] e_op2(input int k);
        return ~64'(k);
    endfunction
    function automatic logic [4:0] e_rd(input int k);
        return 5'(k + 1);
    endfunction
    function automatic logic e_wen(input int k);
        return (k % 3) != 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k);
        valid_i     = 1'b1;
        inst_i      = e_inst(k);
        inst_addr_i = e_addr(k);
        op1_i       = e_op1(k);
        op2_i       = e_op2(k);
        rd_addr_i   = e_rd(k);
        reg_wen_i   = e_wen(k);
    endtask

    task automatic idle_in();
        valid_i     = 1'b0;
        inst_i      = 32'hDEAD_BEEF;
        inst_addr_i = '1;
        op1_i       = '1;
        op2_i       = '1;
        rd_addr_i   = '1;
        reg_wen_i   = 1'b1;
    endtask

    task automatic check_out(input string tag, input int k);
        chk({tag, ".valid"}, 64'(valid_o),     64'd1);
        chk({tag, ".inst"},  64'(inst_o),      64'(e_inst(k)));
        chk({tag, ".addr"},  inst_addr_o,      e_addr(k));
        chk({tag, ".op1"},   op1_o,            e_op1(k));
        chk({tag, ".op2"},   op2_o,            e_op2(k));
        chk({tag, ".rd"},    64'(rd_addr_o),   64'(e_rd(k)));
        chk({tag, ".wen"},   64'(reg_wen_o),   64'(e_wen(k)));
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, ".valid"}, 64'(valid_o),   64'd0);
        chk({tag, ".inst"},  64'(inst_o),    64'h0000_0013);
        chk({tag, ".addr"},  inst_addr_o,    64'd0);
        chk({tag, ".op1"},   op1_o,          64'd0);
        chk({tag, ".op2"},   op2_o,          64'd0);
        chk({tag, ".rd"},    64'(rd_addr_o), 64'd0);
        chk({tag, ".wen"},   64'(reg_wen_o), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two edges while decode offers random junk.
        rst         = 1'b0;
        flush_i     = 1'b0;
        ready_i     = 1'b1;
        valid_i     = 1'b1;
        inst_i      = $urandom;
        inst_addr_i = {$urandom, $urandom};
        op1_i       = {$urandom, $urandom};
        op2_i       = {$urandom, $urandom};
        rd_addr_i   = 5'($urandom);
        reg_wen_i   = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        idle_in();
        check_bubble("reset");
        chk("reset.ready", 64'(ready_o), 64'd1);

        // Back-to-back stream; each payload visible right after its accept edge.
        for (int k = 0; k < 8; k++) begin
            drive(k);
            tick();
            check_out($sformatf("stream%0d", k), k);
        end
        idle_in();
        tick();
        check_bubble("drain");

        // Accept and issue in the same cycle: PC 0x80000000 -> 0x80000004.
        drive(0);
        tick();
        chk("pc0", inst_addr_o, 64'h8000_0000);
        drive(1);
        tick();
        chk("pc1", inst_addr_o, 64'h8000_0004);
        chk("pc1.valid", 64'(valid_o), 64'd1);
        idle_in();
        tick();
        check_bubble("pc.drain");

`ifdef ID_EX_SKID_EN
        // Stall: A held, B lands in S, C held upstream until drain.
        drive(20);
        tick();
        check_out("skA", 20);
        ready_i = 1'b0;
        drive(21);
        #1;
        chk("sk.ready_reg", 64'(ready_o), 64'd1);
        tick();
        check_out("skA.hold", 20);
        chk("sk.ready_low", 64'(ready_o), 64'd0);
        drive(22);
        tick();
        check_out("skA.hold2", 20);
        chk("sk.ready_low2", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        tick();
        check_out("skB", 21);
        chk("sk.ready_back", 64'(ready_o), 64'd1);
        tick();
        check_out("skC", 22);
        idle_in();
        tick();
        check_bubble("sk.drain");

        // Flush while SKID with an offer pending.
        ready_i = 1'b0;
        drive(30);
        tick();
        drive(31);
        tick();
        chk("skf.ready_low", 64'(ready_o), 64'd0);
        drive(32);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle_in();
        check_bubble("skf");
        chk("skf.ready", 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        tick();
        chk("skf.after1", 64'(valid_o), 64'd0);
        tick();
        chk("skf.after2", 64'(valid_o), 64'd0);
`else
        // Empty stage stays ready even when execute stalls.
        ready_i = 1'b0;
        #1;
        chk("ns.ready_empty", 64'(ready_o), 64'd1);
        ready_i = 1'b1;

        // Stall while FULL: ready_o follows ready_i in the same cycle.
        drive(10);
        tick();
        check_out("nsA", 10);
        ready_i = 1'b0;
        drive(11);
        #1;
        chk("ns.ready_low", 64'(ready_o), 64'd0);
        tick();
        check_out("nsA.hold", 10);
        ready_i = 1'b1;
        #1;
        chk("ns.ready_high", 64'(ready_o), 64'd1);
        tick();
        check_out("nsB", 11);
        idle_in();
        tick();
        check_bubble("ns.drain");

        // Flush while FULL and stalled, with a new offer.
        drive(12);
        tick();
        ready_i = 1'b0;
        drive(13);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle_in();
        check_bubble("nsf");
        chk("nsf.ready", 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        tick();
        chk("nsf.after", 64'(valid_o), 64'd0);
`endif

        // Reset mid-operation drops the held instruction.
        ready_i = 1'b0;
        drive(40);
        tick();
        check_out("mr.loaded", 40);
        rst = 1'b0;
        idle_in();
        tick();
        rst     = 1'b1;
        ready_i = 1'b1;
        check_bubble("midreset");
        chk("midreset.ready", 64'(ready_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline stage register with a valid/ready handshake, stall back-pressure, synchronous flush and an optional skid buffer. It sits between the decode stage and the execute stage of the RV64 core. When the stage holds no valid instruction it presents a NOP bubble to execute. It generalises the fixed 32-bit, always-loading ID/EX flop bank to XLEN-wide operands with flow control.

## Interface
Parameters:
- XLEN, 64, width of inst_addr and operands
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- flush_i  in  1  kill all held entries (branch/jump redirect)
- valid_i  in  1  decode offers an instruction
- ready_o  out  1  stage can accept
- inst_i  in  32  instruction word
- inst_addr_i  in  XLEN  PC of instruction
- op1_i, op2_i  in  XLEN  decoded operands
- rd_addr_i  in  REG_AW  destination register
- reg_wen_i  in  1  register write enable
- valid_o  out  1  execute is offered an instruction
- ready_i  in  1  execute can accept (low = stall)
- inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o  out  as inputs  registered payload to execute

## Operation
- Accept = valid_i && ready_o. Issue = valid_o && ready_i.
- Storage: main slot M (drives outputs); skid slot S when skid is compiled in.
- States: EMPTY (M empty), FULL (M valid, S empty), SKID (M and S valid).
- EMPTY: accept -> M <= input, go to FULL.
- FULL:
  - accept && issue -> M <= input, stay in FULL.
  - accept && !issue -> S <= input, go to SKID.
  - !accept && issue -> go to EMPTY.
  - Neither -> hold.
- SKID: ready_o = 0. On issue, M <= S and go to FULL. Otherwise hold.
- Bubble: on any transition into EMPTY, M is loaded with inst=`INST_NOP` and all other fields 0. All outputs are therefore pure flop outputs. reg_wen_o is never 1 while valid_o = 0.
- Flush: highest priority after reset.
  - Next state is EMPTY, with M set to the bubble and S invalidated.
  - An accept in the same cycle is discarded.
  - An issue in the same cycle still counts as consumed by execute.
- Payload is stored unchanged. There is no width conversion; inst is always 32 bits.

## Timing
- Reset (rst = 0 at clk edge):
  - valid_o = 0, inst_o = `INST_NOP`.
  - inst_addr_o, op1_o, op2_o = 0; rd_addr_o = 0; reg_wen_o = 0.
  - ready_o = 1 in the first cycle after reset.
  - Reset mid-operation drops M and S contents.
- Latency: accept in cycle N -> valid_o with that payload in cycle N+1.
- Throughput: 1 instruction/cycle with ready_i held high.
- With skid: ready_o = !S_valid is registered. There is no combinational path ready_i -> ready_o.
- ready_i dropping while FULL: the instruction accepted that cycle lands in S. ready_o goes low the next cycle.
- Flush takes effect at the next edge: valid_o = 0 and ready_o = 1 in cycle N+1.
- valid_o must not depend combinationally on valid_i.

## Configuration
- ID_EX_SKID_EN defined:
  - S slot and SKID state are present.
  - ready_o is registered.
  - Up to 2 instructions are buffered.
- ID_EX_SKID_EN undefined:
  - Only EMPTY/FULL exist.
  - ready_o = !valid_o || ready_i, which is combinational.
  - Accept while FULL && !issue cannot occur.
  - Flush, bubble and reset behaviour are identical in both builds.

## Structure
- `INST_NOP`, default XLEN and the state encodings belong in the shared defines.v header.
- The payload record layout is bundled for slot copies: {inst, inst_addr, op1, op2, rd_addr, reg_wen}.
- One natural sub-module: pipe_slot. It is a payload register with load, clear-to-bubble and valid bit, plus a synchronous active-low reset. It is instantiated once for M and once for S (S only under ID_EX_SKID_EN).
- Control FSM is in id_ex_pipe.

## Test plan
- Reset: drive rst = 0 for 2 cycles with valid_i = 1 and random payload -> after release, valid_o = 0, inst_o = 0x00000013, all other outputs 0, ready_o = 1.
- Stream: 8 instructions back-to-back with ready_i = 1 -> each appears on outputs exactly 1 cycle later, in order, no gaps.
- Stall (skid build): ready_i = 0 while 3 instructions are offered -> A is held on outputs, B goes to S, ready_o = 0 next cycle, C is held upstream. Raise ready_i -> A, B, C issue in order with no loss or duplicate.
- Flush in SKID with valid_i = 1 -> next cycle valid_o = 0, reg_wen_o = 0, inst_o = NOP, ready_o = 1. Neither the held nor the offered instruction ever issues.
- Simultaneous accept and issue in FULL (PC 0x80000000 -> 0x80000004) -> output updates to 0x80000004, state stays FULL.
- No-skid build: ready_i = 0 while FULL -> ready_o = 0 in the same cycle. ready_i = 1 -> ready_o = 1 in the same cycle.
